// File: rtl/fsbm_pkg.sv
// Shared definitions for the full-search block-matching controller:
// FSM state encoding, motion-vector width and default timing parameters.
package fsbm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CMP   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_OUT   = 3'd6
    } state_e;

    localparam int MV_W        = 8;
    localparam int DEF_NUM_BLK = 64;
    localparam int DEF_BLK_PIX = 16;
    localparam int DEF_PE_LAT  = 2;
    localparam int DEF_CMP_LAT = 1;

    // Bits needed to hold every value 0..maxVal, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        if (maxVal <= 1) begin
            return 1;
        end
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/fsbm_cnt.sv
// Up-counter that saturates at a compile-time terminal value and flags it.
// Load has priority over enable; reaching MAX stops counting so no wrap occurs.
module fsbm_cnt
    import fsbm_pkg::*;
#(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise step up until the terminal value is held.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == MAX_V);

endmodule

// File: rtl/fsbm_ctrl.sv
// Sequencer for a 16-PE full-search block-matching engine: per block it
// clears the SAD accumulators, streams BLK_PIX pixels, waits for the PE and
// comparator pipelines, then offers the winning vector on a valid/ready port.
module fsbm_ctrl
    import fsbm_pkg::*;
#(
    parameter int NUM_BLK = DEF_NUM_BLK,
    parameter int BLK_PIX = DEF_BLK_PIX,
    parameter int PE_LAT  = DEF_PE_LAT,
    parameter int CMP_LAT = DEF_CMP_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic [7:0]      blk_idx,
    output logic [3:0]      pix_cnt,
    output logic            pe_clr,
    output logic            pe_acc,
    output logic            cmp_en,
    input  logic [MV_W-1:0] cmp_mv,
    output logic            mv_valid,
    input  logic            mv_ready,
    output logic [MV_W-1:0] mv_out,
    output logic [7:0]      mv_blk,
    output logic            done
);

    // One delay counter spans DRAIN, CMP and WAIT; its terminal value marks
    // the last WAIT cycle and an intermediate value marks the last DRAIN cycle.
    localparam int PIX_W   = cntWidth(BLK_PIX - 1);
    localparam int DLY_MAX = PE_LAT + CMP_LAT;
    localparam int DLY_W   = cntWidth(DLY_MAX);
    localparam logic [DLY_W-1:0] DRAIN_LAST = DLY_W'(PE_LAT - 1);

    state_e state_q;
    state_e state_d;

    logic [PIX_W-1:0] pixCnt;
    logic             pixTc;
    logic [DLY_W-1:0] dlyCnt;
    logic             dlyTc;
    logic [7:0]       blkCnt;
    logic             blkTc;

    logic             abortHit;
    logic             startAcc;
    logic             handshake;
    logic             inDelay;
    logic             nextInDelay;

    logic [MV_W-1:0]  mv_out_q;
    logic [MV_W-1:0]  mv_out_d;
    logic [7:0]       mv_blk_q;
    logic [7:0]       mv_blk_d;
    logic             done_q;
    logic             done_d;

    assign abortHit    = abort && (state_q != ST_IDLE);
    assign startAcc    = (state_q == ST_IDLE) && start && !abort;
    assign handshake   = (state_q == ST_OUT) && mv_ready;
    assign inDelay     = state_q inside {ST_DRAIN, ST_CMP, ST_WAIT};
    assign nextInDelay = state_d inside {ST_DRAIN, ST_CMP, ST_WAIT};

    // Next-state logic; abort outside IDLE overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && !abort) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_LOAD;
            ST_LOAD:  if (pixTc) state_d = ST_DRAIN;
            ST_DRAIN: if (dlyCnt == DRAIN_LAST) state_d = ST_CMP;
            ST_CMP:   state_d = ST_WAIT;
            ST_WAIT:  if (dlyTc) state_d = ST_OUT;
            ST_OUT:   if (mv_ready) state_d = blkTc ? ST_IDLE : ST_CLEAR;
            default:  state_d = ST_IDLE;
        endcase
        if (abortHit) begin
            state_d = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pixel index: held at zero outside LOAD so it reads 0 whenever idle.
    fsbm_cnt #(.W(PIX_W), .MAX(BLK_PIX - 1)) u_pix_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_d != ST_LOAD),
        .load_val_i ('0),
        .en_i       (state_q == ST_LOAD),
        .cnt_o      (pixCnt),
        .tc_o       (pixTc)
    );

    // Pipeline delay through DRAIN, CMP and WAIT.
    fsbm_cnt #(.W(DLY_W), .MAX(DLY_MAX)) u_dly_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (!nextInDelay),
        .load_val_i ('0),
        .en_i       (inDelay),
        .cnt_o      (dlyCnt),
        .tc_o       (dlyTc)
    );

    // Block index: restarts on accepted start or abort, steps on a non-final handshake.
    fsbm_cnt #(.W(8), .MAX(NUM_BLK - 1)) u_blk_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (startAcc || abortHit),
        .load_val_i (8'd0),
        .en_i       (handshake && !blkTc),
        .cnt_o      (blkCnt),
        .tc_o       (blkTc)
    );

    // Vector capture on the last WAIT cycle, cleared by abort; done on final handshake.
    always_comb begin
        mv_out_d = mv_out_q;
        mv_blk_d = mv_blk_q;
        done_d   = handshake && blkTc && !abortHit;
        if (abortHit) begin
            mv_out_d = '0;
            mv_blk_d = '0;
        end else if ((state_q == ST_WAIT) && dlyTc) begin
            mv_out_d = cmp_mv;
            mv_blk_d = blkCnt;
        end
    end

    // Output registers for the vector port and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mv_out_q <= '0;
            mv_blk_q <= '0;
            done_q   <= 1'b0;
        end else begin
            mv_out_q <= mv_out_d;
            mv_blk_q <= mv_blk_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign pe_clr   = (state_q == ST_CLEAR);
    assign pe_acc   = (state_q == ST_LOAD);
    assign cmp_en   = (state_q == ST_CMP);
    assign mv_valid = (state_q == ST_OUT);
    assign pix_cnt  = 4'(pixCnt);
    assign blk_idx  = blkCnt;
    assign mv_out   = mv_out_q;
    assign mv_blk   = mv_blk_q;
    assign done     = done_q;

endmodule
